// File: rtl/mem_bist_gen.sv
// mem_bist_gen: write / read-back memory self-test traffic generator.
// Optional: define BIST_STOP_ON_ERR_EN to end a run at the first mismatch.
module mem_bist_gen #(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_WORDS  = 65536,
  parameter int unsigned ADDR_STEP  = 1,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_rw,
  output logic              req_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [1:0]        phase
);

  localparam int unsigned IDX_W =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned GAP_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  // Right-shift Galois feedback masks; other widths use a
  // shifted 64-bit mask, which still gives a usable sequence.
  localparam logic [63:0] TAPS64 =
    (DATA_W == 8)  ? 64'h00000000000000B8 :
    (DATA_W == 16) ? 64'h000000000000B400 :
    (DATA_W == 32) ? 64'h0000000080200003 :
    (64'hD800000000000000 >> (64 - DATA_W));
  localparam logic [DATA_W-1:0] LFSR_TAPS = TAPS64[DATA_W-1:0];

  localparam logic [63:0] P55_64 = {32{2'b01}};
  localparam logic [63:0] PAA_64 = {32{2'b10}};
  localparam logic [DATA_W-1:0] PAT_55 = P55_64[DATA_W-1:0];
  localparam logic [DATA_W-1:0] PAT_AA = PAA_64[DATA_W-1:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WGAP  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RGAP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] lfsr_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] fa_q;
  logic [DATA_W-1:0] fd_q;
  logic [DATA_W-1:0] idx_pat;
  logic [DATA_W-1:0] pat;
  logic              in_wr;
  logic              in_rd;
  logic              last;
  logic              mism;
  logic              stop_hit;

  if (IDX_W >= DATA_W) begin : g_trunc
    assign idx_pat = idx[DATA_W-1:0];
  end else begin : g_ext
    assign idx_pat = {{(DATA_W-IDX_W){1'b0}}, idx};
  end

  assign lfsr_nxt = (lfsr >> 1) ^
    (lfsr[0] ? LFSR_TAPS : '0);

  assign in_wr = (state == S_WRITE);
  assign in_rd = (state == S_READ);
  assign last  = (idx == LAST_IDX);
  assign mism  = (res_data != pat);

`ifdef BIST_STOP_ON_ERR_EN
  assign stop_hit = mism;
`else
  assign stop_hit = 1'b0;
`endif

  // Data pattern for the current word index
  always_comb begin
    pat = idx_pat;
    unique case (1'b1)
      mode_q == 2'd1: pat = ~idx_pat;
      mode_q == 2'd2: pat = lfsr;
      mode_q == 2'd3: pat = idx[0] ? PAT_AA : PAT_55;
      default:        pat = idx_pat;
    endcase
  end

  // Externally visible phase; gaps report the phase they sit in
  always_comb begin
    phase = 2'd0;
    unique case (1'b1)
      in_wr || state == S_WGAP: phase = 2'd1;
      in_rd || state == S_RGAP: phase = 2'd2;
      state == S_DONE:          phase = 2'd3;
      default:                  phase = 2'd0;
    endcase
  end

  assign req_valid = in_wr | in_rd;
  assign req_rw    = in_wr;
  assign req_addr  = addr_q;
  assign req_data  = in_wr ? pat : '0;
  assign busy      = (phase == 2'd1) || (phase == 2'd2);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;

  // Run sequencing, window walk and first-failure capture
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      mode_q  <= '0;
      idx     <= '0;
      lfsr    <= '0;
      addr_q  <= '0;
      gap_cnt <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_WRITE;
            mode_q <= mode;
            idx    <= '0;
            lfsr   <= '1;
            addr_q <= BASE;
            err_q  <= '0;
            fa_q   <= '0;
            fd_q   <= '0;
          end
        end
        S_WRITE: begin
          if (res_ready) begin
            gap_cnt <= GAP_LOAD;
            if (last) begin
              idx    <= '0;
              lfsr   <= '1;
              addr_q <= BASE;
              state  <= NO_GAP ? S_READ : S_RGAP;
            end else begin
              idx    <= idx + IDX_W'(1);
              lfsr   <= lfsr_nxt;
              addr_q <= addr_q + STEP;
              state  <= NO_GAP ? S_WRITE : S_WGAP;
            end
          end
        end
        S_WGAP, S_RGAP: begin
          if (gap_cnt == '0) begin
            state <= (state == S_WGAP) ? S_WRITE : S_READ;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_READ: begin
          if (res_ready) begin
            gap_cnt <= GAP_LOAD;
            if (mism) begin
              if (err_q != '1) err_q <= err_q + ERR_W'(1);
              if (err_q == '0) begin
                fa_q <= addr_q;
                fd_q <= res_data;
              end
            end
            if (last || stop_hit) begin
              state <= S_DONE;
            end else begin
              idx    <= idx + IDX_W'(1);
              lfsr   <= lfsr_nxt;
              addr_q <= addr_q + STEP;
              state  <= NO_GAP ? S_READ : S_RGAP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_gen.sv
// tb_mem_bist_gen: two generator instances against a behavioural memory.
// Unit 0: 4 words, 1 gap cycle. Unit 1: 8 words, no gap, 2-bit errors.
module tb_mem_bist_gen;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rstn  [2];
  logic        start [2];
  logic [1:0]  mode  [2];
  logic        rdy   [2];
  logic [31:0] rdat  [2];
  logic [26:0] addr  [2];
  logic [31:0] wdat  [2];
  logic        rw    [2];
  logic        valid [2];
  logic        busy  [2];
  logic        done  [2];
  logic        pass  [2];
  logic [26:0] faddr [2];
  logic [31:0] fdata [2];
  logic [1:0]  phase [2];
  logic [15:0] err_a;
  logic [1:0]  err_b;

  mem_bist_gen #(
    .ADDR_W(27), .DATA_W(32), .BASE_ADDR(32'h100),
    .NUM_WORDS(4), .ADDR_STEP(1), .GAP_CYCLES(1), .ERR_W(16)
  ) dut_a (
    .sys_clk(sys_clk), .rstn(rstn[0]), .start(start[0]),
    .mode(mode[0]), .req_addr(addr[0]), .req_data(wdat[0]),
    .req_rw(rw[0]), .req_valid(valid[0]), .res_data(rdat[0]),
    .res_ready(rdy[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_a), .fail_addr(faddr[0]),
    .fail_data(fdata[0]), .phase(phase[0])
  );

  mem_bist_gen #(
    .ADDR_W(27), .DATA_W(32), .BASE_ADDR(32'h100),
    .NUM_WORDS(8), .ADDR_STEP(1), .GAP_CYCLES(0), .ERR_W(2)
  ) dut_b (
    .sys_clk(sys_clk), .rstn(rstn[1]), .start(start[1]),
    .mode(mode[1]), .req_addr(addr[1]), .req_data(wdat[1]),
    .req_rw(rw[1]), .req_valid(valid[1]), .res_data(rdat[1]),
    .res_ready(rdy[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_b), .fail_addr(faddr[1]),
    .fail_data(fdata[1]), .phase(phase[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [longint];
  int          stall;
  bit          rand_lat;
  bit          read_zero;
  bit          bad_en;
  logic [26:0] bad_addr;
  bit          q_rw [$];
  logic [26:0] q_addr [$];
  logic [31:0] q_data [$];
  int          q_gap [$];
  int          idle;
  bit          want_gap;

  function automatic int nw(int u);
    return (u == 0) ? 4 : 8;
  endfunction

  function automatic int gapc(int u);
    return (u == 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] errv(int u);
    return (u == 0) ? err_a : {14'd0, err_b};
  endfunction

  // Expected word for pattern m at index i
  function automatic logic [31:0] pat(int m, int i);
    logic [31:0] s;
    s = '1;
    case (m)
      0: return 32'(i);
      1: return ~32'(i);
      2: begin
        for (int k = 0; k < i; k++)
          s = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
        return s;
      end
      default:
        return (i % 2 == 1) ? 32'hAAAAAAAA : 32'h55555555;
    endcase
  endfunction

  // Distance of the logged traffic from the expected sequence
  function automatic int log_errs(int m, int w, int r);
    int e;
    int k;
    bit wr;
    e = 0;
    if (q_rw.size() != w + r) return 1000 + q_rw.size();
    for (int i = 0; i < w + r; i++) begin
      wr = (i < w);
      k = wr ? i : i - w;
      if (q_rw[i] != wr) e++;
      if (q_addr[i] !== 27'(32'h100 + k)) e++;
      if (wr && q_data[i] !== pat(m, k)) e++;
    end
    return e;
  endfunction

  function automatic int gap_errs(int g, int ntx);
    int e;
    e = 0;
    if (q_gap.size() != ntx - 1) return 1000 + q_gap.size();
    foreach (q_gap[i]) if (q_gap[i] != g) e++;
    return e;
  endfunction

  function automatic longint key(int u, logic [26:0] a);
    return longint'(u) * 64'h1_0000_0000 + longint'(a);
  endfunction

  task automatic clear_log();
    q_rw.delete();
    q_addr.delete();
    q_data.delete();
    q_gap.delete();
    idle = 0;
    want_gap = 1'b0;
  endtask

  // One memory cycle: retire, record gaps, accept the next request
  task automatic mem_step(input int u);
    @(negedge sys_clk);
    if (rdy[u]) begin
      rdy[u] = 1'b0;
      want_gap = 1'b1;
      idle = 0;
      if (rand_lat) stall = $urandom_range(0, 3);
    end
    if (valid[u]) begin
      if (want_gap) begin
        q_gap.push_back(idle);
        want_gap = 1'b0;
      end
      if (stall > 0) begin
        stall--;
      end else begin
        rdy[u] = 1'b1;
        q_rw.push_back(rw[u]);
        q_addr.push_back(addr[u]);
        if (rw[u]) begin
          mem[key(u, addr[u])] = wdat[u];
          q_data.push_back(wdat[u]);
        end else begin
          if (read_zero) rdat[u] = 32'h0;
          else if (bad_en && addr[u] == bad_addr) rdat[u] = 32'hDEAD;
          else if (mem.exists(key(u, addr[u])))
            rdat[u] = mem[key(u, addr[u])];
          else rdat[u] = 32'h0;
          q_data.push_back(rdat[u]);
        end
      end
    end else begin
      idle++;
    end
  endtask

  task automatic start_run(input int u, input int m);
    clear_log();
    @(negedge sys_clk);
    start[u] = 1'b1;
    mode[u] = 2'(m);
    @(posedge sys_clk);
    #1;
    start[u] = 1'b0;
    mode[u] = 2'($urandom);
  endtask

  task automatic run_to_done(input int u, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      mem_step(u);
      if (done[u]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_chk++;
      if ({valid[u], rw[u], busy[u], done[u], pass[u], phase[u]}
          !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d]: got %b want 0", u,
          {valid[u], rw[u], busy[u], done[u], pass[u], phase[u]});
      end
      n_chk++;
      if (addr[u] !== 27'd0 || wdat[u] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_req[%0d]: addr %h data %h want 0",
          u, addr[u], wdat[u]);
      end
      n_chk++;
      if (errv(u) !== 16'd0 || faddr[u] !== 27'd0 ||
          fdata[u] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_err[%0d]: err %h fa %h fd %h want 0",
          u, errv(u), faddr[u], fdata[u]);
      end
    end
    @(negedge sys_clk);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int e;
    start_run(0, 0);
    run_to_done(0, 200, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done: got timeout want done");
    end
    e = log_errs(0, 4, 4);
    n_chk++;
    if (e != 0) begin
      n_fail++;
      $display("FAIL basic_log: %0d bad entries want 0", e);
    end
    e = gap_errs(1, 8);
    n_chk++;
    if (e != 0) begin
      n_fail++;
      $display("FAIL basic_gap: %0d bad gaps want 0", e);
    end
    n_chk++;
    if ({pass[0], busy[0], phase[0]} !== 4'b1011 ||
        err_a !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_status: pass/busy/phase %b err %0d want 1011 0",
        {pass[0], busy[0], phase[0]}, err_a);
    end
  endtask

  task automatic test_lfsr_nogap();
    bit ok;
    int e;
    start_run(1, 2);
    run_to_done(1, 200, ok);
    e = log_errs(2, 8, 8);
    n_chk++;
    if (!ok || e != 0) begin
      n_fail++;
      $display("FAIL lfsr_log: ok %0d bad %0d want 1 0", ok, e);
    end
    e = gap_errs(0, 16);
    n_chk++;
    if (e != 0) begin
      n_fail++;
      $display("FAIL lfsr_gap: %0d bad gaps want 0", e);
    end
    n_chk++;
    if (pass[1] !== 1'b1 || err_b !== 2'd0) begin
      n_fail++;
      $display("FAIL lfsr_pass: pass %b err %0d want 1 0",
        pass[1], err_b);
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    int e;
    int nr;
`ifdef BIST_STOP_ON_ERR_EN
    nr = 3;
`else
    nr = 4;
`endif
    bad_en = 1'b1;
    bad_addr = 27'h102;
    start_run(0, 0);
    run_to_done(0, 200, ok);
    bad_en = 1'b0;
    e = log_errs(0, 4, nr);
    n_chk++;
    if (!ok || e != 0) begin
      n_fail++;
      $display("FAIL corrupt_log: ok %0d bad %0d want 1 0", ok, e);
    end
    n_chk++;
    if (err_a !== 16'd1 || pass[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL corrupt_err: err %0d pass %b want 1 0",
        err_a, pass[0]);
    end
    n_chk++;
    if (faddr[0] !== 27'h102 || fdata[0] !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL corrupt_cap: fa %h fd %h want 102 dead",
        faddr[0], fdata[0]);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int e;
    stall = 20;
    start_run(0, 0);
    for (int c = 0; c < 20; c++) begin
      mem_step(0);
      n_chk++;
      if (!(valid[0] && rw[0] && !rdy[0]) ||
          addr[0] !== 27'h100 || wdat[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v%b rw%b a %h d %h want 1 1 100 0",
          c, valid[0], rw[0], addr[0], wdat[0]);
      end
    end
    mem_step(0);
    n_chk++;
    if (rdy[0] !== 1'b1 || addr[0] !== 27'h100) begin
      n_fail++;
      $display("FAIL stall_release: rdy %b addr %h want 1 100",
        rdy[0], addr[0]);
    end
    run_to_done(0, 200, ok);
    e = log_errs(0, 4, 4);
    n_chk++;
    if (!ok || e != 0 || pass[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_run: ok %0d bad %0d pass %b want 1 0 1",
        ok, e, pass[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    int e;
    logic [15:0] exp_err;
`ifdef BIST_STOP_ON_ERR_EN
    exp_err = 16'd0;
`else
    exp_err = 16'd1;
    bad_en = 1'b1;
    bad_addr = 27'h101;
`endif
    start_run(0, 0);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      mem_step(0);
      hit = valid[0] && !rw[0] && addr[0] == 27'h103 && rdy[0];
    end
    n_chk++;
    if (!hit || err_a !== exp_err) begin
      n_fail++;
      $display("FAIL rmid_reach: hit %0d err %0d want 1 %0d",
        hit, err_a, exp_err);
    end
    rstn[0] = 1'b0;
    @(posedge sys_clk);
    #1;
    n_chk++;
    if ({valid[0], busy[0], phase[0]} !== 4'd0 ||
        err_a !== 16'd0 || faddr[0] !== 27'd0) begin
      n_fail++;
      $display("FAIL rmid_reset: v/b/ph %b err %0d fa %h want 0",
        {valid[0], busy[0], phase[0]}, err_a, faddr[0]);
    end
    @(negedge sys_clk);
    rdy[0] = 1'b0;
    rstn[0] = 1'b1;
    bad_en = 1'b0;
    start_run(0, 0);
    run_to_done(0, 200, ok);
    e = log_errs(0, 4, 4);
    n_chk++;
    if (!ok || e != 0 || pass[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_rerun: ok %0d bad %0d pass %b want 1 0 1",
        ok, e, pass[0]);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int e;
    int nr;
    logic [1:0] exp_err;
`ifdef BIST_STOP_ON_ERR_EN
    nr = 1;
    exp_err = 2'd1;
`else
    nr = 8;
    exp_err = 2'd3;
`endif
    read_zero = 1'b1;
    start_run(1, 1);
    run_to_done(1, 200, ok);
    read_zero = 1'b0;
    e = log_errs(1, 8, nr);
    n_chk++;
    if (!ok || e != 0) begin
      n_fail++;
      $display("FAIL sat_log: ok %0d bad %0d want 1 0", ok, e);
    end
    n_chk++;
    if (err_b !== exp_err || pass[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_err: err %0d pass %b want %0d 0",
        err_b, pass[1], exp_err);
    end
    n_chk++;
    if (faddr[1] !== 27'h100 || fdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL sat_cap: fa %h fd %h want 100 0",
        faddr[1], fdata[1]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e;
    start_run(0, 0);
    repeat (3) mem_step(0);
    start[0] = 1'b1;
    mode[0] = 2'd2;
    repeat (2) mem_step(0);
    start[0] = 1'b0;
    run_to_done(0, 200, ok);
    e = log_errs(0, 4, 4);
    n_chk++;
    if (!ok || e != 0) begin
      n_fail++;
      $display("FAIL b2b_busy_start: ok %0d bad %0d want 1 0", ok, e);
    end
    start_run(0, 3);
    run_to_done(0, 200, ok);
    e = log_errs(3, 4, 4);
    n_chk++;
    if (!ok || e != 0 || pass[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: ok %0d bad %0d pass %b want 1 0 1",
        ok, e, pass[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int e;
    int g;
    int u;
    int m;
    for (int k = 0; k < 6; k++) begin
      u = $urandom_range(0, 1);
      m = $urandom_range(0, 3);
      rand_lat = 1'b1;
      stall = $urandom_range(0, 3);
      start_run(u, m);
      run_to_done(u, 500, ok);
      e = log_errs(m, nw(u), nw(u));
      g = gap_errs(gapc(u), 2 * nw(u));
      n_chk++;
      if (!ok || e != 0 || g != 0) begin
        n_fail++;
        $display("FAIL rand[%0d] u%0d m%0d: ok %0d bad %0d gaps %0d want 1 0 0",
          k, u, m, ok, e, g);
      end
      n_chk++;
      if (pass[u] !== 1'b1 || errv(u) !== 16'd0) begin
        n_fail++;
        $display("FAIL rand_pass[%0d]: pass %b err %0d want 1 0",
          k, pass[u], errv(u));
      end
    end
    rand_lat = 1'b0;
    stall = 0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rstn[u] = 1'b0;
      start[u] = 1'b0;
      mode[u] = 2'd0;
      rdy[u] = 1'b0;
      rdat[u] = 32'd0;
    end
    stall = 0;
    rand_lat = 1'b0;
    read_zero = 1'b0;
    bad_en = 1'b0;
    bad_addr = 27'd0;
    clear_log();
    test_reset();
    test_basic();
    test_lfsr_nogap();
    test_corrupt();
    test_stall();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bist_gen.md
Name: mem_bist_gen

Overview:
- Synthesizable memory self-test traffic generator for on-board bring-up of the cache/DDR2 path.
- Writes a configurable address window with a selectable data pattern, reads the window back and compares each word.
- Reports pass/fail, an error count and the first failing address/data for LED and ILA observation.
- Drives the same req/res handshake as the CPU side of the memory subsystem.

Parameters:
- ADDR_W, 27: request address width.
- DATA_W, 32: data width; must be 8..64.
- BASE_ADDR, 0: first word address of the test window.
- NUM_WORDS, 65536: number of words tested; must be ≥ 1.
- ADDR_STEP, 1: address increment per word.
- GAP_CYCLES, 1: idle cycles with req_valid low after each completed transaction; may be 0.
- ERR_W, 16: error counter width.

Ports:
- sys_clk, in, 1: clock.
- rstn, in, 1: reset, synchronous, active-low.
- start, in, 1: level-sampled; starts a run when the block is IDLE or DONE.
- mode, in, 2: pattern select, sampled at start. 0 = address, 1 = ~address, 2 = LFSR, 3 = alternating 0x55../0xAA.. by word index.
- req_addr, out, ADDR_W: request address.
- req_data, out, DATA_W: write data.
- req_rw, out, 1: 1 = write, 0 = read.
- req_valid, out, 1: request valid.
- res_data, in, DATA_W: read data.
- res_ready, in, 1: transaction complete this cycle.
- busy, out, 1: high from the run start until DONE.
- done, out, 1: high in DONE.
- pass, out, 1: done && err_count == 0.
- err_count, out, ERR_W: saturating mismatch count.
- fail_addr, out, ADDR_W: address of the first mismatch.
- fail_data, out, DATA_W: read data of the first mismatch.
- phase, out, 2: 0 idle, 1 write, 2 read, 3 done.

Behaviour:
- Reset (rstn low at a sys_clk edge):
  - State goes to IDLE; all outputs go to 0, including req_valid.
  - Reset takes effect mid-transaction as well; the pending request is abandoned.
- States and transitions:
  - IDLE → WRITE on start. On that edge: latch mode, clear err_count/fail_addr/fail_data, set index to 0, seed LFSR to all-ones.
  - WRITE: req_valid = 1, req_rw = 1, req_addr = BASE_ADDR + index*ADDR_STEP (mod 2^ADDR_W), req_data = pattern(index).
  - Handshake: a transaction completes on a cycle with req_valid && res_ready. Address, data and rw stay stable until then.
  - After each completion go to WGAP for GAP_CYCLES cycles with req_valid = 0, then return to WRITE with index+1.
  - If GAP_CYCLES = 0, the next request is presented the following cycle.
  - On completion of index NUM_WORDS-1 → READ: index reset to 0, LFSR reseeded to all-ones so read expectations replay the write sequence.
  - READ: same handshake with req_rw = 0.
    - On completion, compare res_data against pattern(index).
    - On mismatch: err_count increments, saturating at all-ones.
    - On the first mismatch only: fail_addr and fail_data are captured.
    - RGAP behaves as WGAP.
  - Completion of the last read → DONE.
  - DONE: req_valid = 0; done = 1. start → WRITE, as from IDLE.
- Patterns:
  - Address pattern is the index zero-extended or truncated to DATA_W.
  - LFSR is DATA_W-wide Galois, advanced once per completed transaction.
  - Pattern 3 gives 0x55.. for even index and 0xAA.. for odd index.
- start while busy is ignored; mode changes while busy are ignored.
- res_ready while req_valid = 0 is ignored, with no state change.
- NUM_WORDS = 1: exactly one write then one read.

Optional Feature:
- Macro BIST_STOP_ON_ERR_EN.
- Defined: the first mismatch moves the block straight to DONE. err_count = 1 and pass = 0; remaining reads are not issued.
- Undefined: all NUM_WORDS reads are issued and all mismatches are counted.

Test Plan:
- NUM_WORDS = 4, BASE_ADDR = 0x100, mode 0, ideal memory with res_ready 1 cycle after valid. Expected:
  - Writes to 0x100..0x103 with data 0..3, then reads of the same addresses.
  - done, pass = 1, err_count = 0.
  - Exactly one idle cycle between transactions (GAP_CYCLES = 1).
- mode 2, NUM_WORDS = 8, GAP_CYCLES = 0 → read expectations equal the written LFSR values; pass = 1; no idle cycles between transactions.
- Memory model corrupts address 0x102 to 0xDEAD (mode 0, BASE_ADDR = 0x100) → err_count = 1, fail_addr = 0x102, fail_data = 0xDEAD, pass = 0.
- res_ready held low 20 cycles on one write → req_addr, req_data and req_rw stay stable for all 20 cycles, and index does not advance.
- rstn low during READ index 3 → next cycle req_valid = 0, phase = 0, err_count = 0. start then reruns the test from index 0.
- ERR_W = 2, memory returns 0 for every read with mode 1 → err_count saturates at 3. With BIST_STOP_ON_ERR_EN defined, DONE follows the first read with err_count = 1.
